// File: rtl/pwm_defs.sv
// pwm_defs: shared mode and count-direction encodings for the multi-channel PWM
package pwm_defs;
   typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} mode_e;
   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: free-running divider, o_tick once every i_final+1 clocks
// Ports: clk, reset_n (async low), i_enable (count), i_clear (sync clear),
//        i_final (terminal count), o_tick (high while count == i_final)
module pwm_prescaler #(
   parameter int TIMER_BITS = 15
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_enable,
   input  logic                  i_clear,
   input  logic [TIMER_BITS-1:0] i_final,
   output logic                  o_tick
);
   logic [TIMER_BITS-1:0] r_cnt;
   assign o_tick = i_enable && !i_clear && (r_cnt == i_final);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_cnt <= '0;
      else if (i_clear)
         r_cnt <= '0;
      else if (i_enable)
         r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
   end
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: CHANNELS PWM outputs on one shared prescaler and period counter
// Ports: clk, reset_n (async low), enable, FINAL_VALUE (prescaler terminal),
//        cfg_wr/period/mode/duty (config strobe and data, double-buffered),
//        pwm_out (registered), period_tick (period start), update_ack (config applied)
module pwm_multi
   import pwm_defs::*;
#(
   parameter int CHANNELS   = 4,
   parameter int R          = 8,
   parameter int TIMER_BITS = 15
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic [TIMER_BITS-1:0]     FINAL_VALUE,
   input  logic                      cfg_wr,
   input  logic [R-1:0]              period,
   input  logic                      mode,
   input  logic [CHANNELS*(R+1)-1:0] duty,
   output logic [CHANNELS-1:0]       pwm_out,
   output logic                      period_tick,
   output logic                      update_ack
);
   localparam int DW = CHANNELS*(R+1);
   logic [R-1:0]        r_cnt;
   dir_e                r_dir;
   logic                r_run;
   logic [R-1:0]        r_act_period;
   mode_e               r_act_mode;
   logic [DW-1:0]       r_act_duty;
   logic [R-1:0]        r_pend_period;
   mode_e               r_pend_mode;
   logic [DW-1:0]       r_pend_duty;
   logic                r_pend;
   logic [CHANNELS-1:0] r_pwm;
   logic                r_period_tick;
   logic                r_update_ack;
   logic                w_tick;
   logic                w_start;
   logic                w_top;
   logic [R-1:0]        w_run_cnt;
   dir_e                w_run_dir;
   logic                w_run_bnd;
   logic                w_apply;
   logic [R-1:0]        w_period_n;
   mode_e               w_mode_n;
   logic [DW-1:0]       w_duty_n;
   logic [R-1:0]        w_cnt_n;
   dir_e                w_dir_n;
   logic                w_live;
   logic                w_bnd;
   logic [CHANNELS-1:0] w_pwm_n;
   pwm_prescaler #(.TIMER_BITS(TIMER_BITS)) u_prescaler (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_enable (enable),
      .i_clear  (!enable),
      .i_final  (FINAL_VALUE),
      .o_tick   (w_tick)
   );
   // A "start" tick (first tick after enable, or any tick while the active
   // period is 0) opens a fresh period at count 0 and may take pending config.
   always_comb begin
      w_start   = !r_run || (r_act_period == '0);
      w_top     = r_cnt >= r_act_period - R'(1);
      w_run_cnt = r_cnt;
      w_run_dir = r_dir;
      w_run_bnd = 1'b0;
      if (r_act_mode == MODE_EDGE) begin
         w_run_cnt = w_top ? '0 : r_cnt + R'(1);
         w_run_dir = DIR_UP;
         w_run_bnd = w_top;
      end else if (r_dir == DIR_UP) begin
         w_run_cnt = w_top ? r_cnt : r_cnt + R'(1);
         w_run_dir = w_top ? DIR_DOWN : DIR_UP;
      end else begin
         w_run_cnt = (r_cnt == '0) ? r_cnt : r_cnt - R'(1);
         w_run_dir = (r_cnt == '0) ? DIR_UP : DIR_DOWN;
         w_run_bnd = (r_cnt == '0);
      end
      w_apply    = w_tick && r_pend && (w_start || w_run_bnd);
      w_period_n = w_apply ? r_pend_period : r_act_period;
      w_mode_n   = w_apply ? r_pend_mode : r_act_mode;
      w_duty_n   = w_apply ? r_pend_duty : r_act_duty;
      w_live     = w_period_n != '0;
      w_cnt_n    = w_start ? '0 : w_run_cnt;
      w_dir_n    = w_start ? DIR_UP : w_run_dir;
      w_bnd      = w_start ? w_live : w_run_bnd;
   end
   // Compare against the post-update duty so a new setting takes effect on the boundary tick itself.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      assign w_pwm_n[i] = w_live && ({1'b0, w_cnt_n} < w_duty_n[i*(R+1) +: R+1]);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt         <= '0;
         r_dir         <= DIR_UP;
         r_run         <= 1'b0;
         r_act_period  <= '0;
         r_act_mode    <= MODE_EDGE;
         r_act_duty    <= '0;
         r_pend_period <= '0;
         r_pend_mode   <= MODE_EDGE;
         r_pend_duty   <= '0;
         r_pend        <= 1'b0;
         r_pwm         <= '0;
         r_period_tick <= 1'b0;
         r_update_ack  <= 1'b0;
      end else if (!enable) begin
         r_cnt         <= '0;
         r_dir         <= DIR_UP;
         r_run         <= 1'b0;
         r_pwm         <= '0;
         r_period_tick <= 1'b0;
         r_update_ack  <= cfg_wr;
         if (cfg_wr) begin
            r_act_period <= period;
            r_act_mode   <= mode_e'(mode);
            r_act_duty   <= duty;
            r_pend       <= 1'b0;
         end
      end else begin
         r_period_tick <= w_tick && w_bnd;
         r_update_ack  <= w_apply;
         r_act_period  <= w_period_n;
         r_act_mode    <= w_mode_n;
         r_act_duty    <= w_duty_n;
         if (w_tick) begin
            r_cnt <= w_cnt_n;
            r_dir <= w_dir_n;
            r_run <= w_live;
            r_pwm <= w_pwm_n;
         end
         // A write on the boundary clk refills pending, so the flag stays set.
         if (cfg_wr) begin
            r_pend_period <= period;
            r_pend_mode   <= mode_e'(mode);
            r_pend_duty   <= duty;
            r_pend        <= 1'b1;
         end else if (w_apply)
            r_pend <= 1'b0;
      end
   end
   assign pwm_out     = r_pwm;
   assign period_tick = r_period_tick;
   assign update_ack  = r_update_ack;
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi
module tb_pwm_multi;
   logic        clk;
   logic        reset_n;
   logic        enable;
   logic [14:0] FINAL_VALUE;
   logic        cfg_wr;
   logic [7:0]  period;
   logic        mode;
   logic [35:0] duty;
   logic [3:0]  pwm_out;
   logic        period_tick;
   logic        update_ack;
   int          checks = 0;
   int          errors = 0;
   int          m_hi [4];
   int          m_ticks, m_acks, m_first, m_imin, m_imax;
   logic [3:0]  m_log [0:127];
   pwm_multi #(.CHANNELS(4), .R(8), .TIMER_BITS(15)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .FINAL_VALUE (FINAL_VALUE),
      .cfg_wr      (cfg_wr),
      .period      (period),
      .mode        (mode),
      .duty        (duty),
      .pwm_out     (pwm_out),
      .period_tick (period_tick),
      .update_ack  (update_ack)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   function automatic logic [35:0] pk(input int d0, input int d1, input int d2, input int d3);
      pk = {9'(d3), 9'(d2), 9'(d1), 9'(d0)};
   endfunction
   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic measure(input int n);
      int last;
      m_ticks = 0; m_acks = 0; m_first = -1; m_imin = 1000000; m_imax = 0; last = -1;
      for (int c = 0; c < 4; c++) m_hi[c] = 0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         #1;
         m_log[k] = pwm_out;
         for (int c = 0; c < 4; c++) if (pwm_out[c]) m_hi[c]++;
         if (update_ack) m_acks++;
         if (period_tick) begin
            m_ticks++;
            if (m_first < 0) m_first = k;
            else begin
               if (k - last < m_imin) m_imin = k - last;
               if (k - last > m_imax) m_imax = k - last;
            end
            last = k;
         end
      end
   endtask
   initial begin
      reset_n = 0; enable = 0; FINAL_VALUE = 0; cfg_wr = 0; period = 0; mode = 0; duty = '0;
      step(2);
      chk("reset_pwm", pwm_out, 0);
      chk("reset_tick", period_tick, 0);
      chk("reset_ack", update_ack, 0);
      reset_n = 1;
      step(1);
      chk("idle_pwm", pwm_out, 0);
      // edge mode P=10, duties {0,3,10,12}, loaded while stopped
      period = 10; mode = 0; duty = pk(0, 3, 10, 12); cfg_wr = 1;
      step(1);
      cfg_wr = 0;
      chk("en0_ack", update_ack, 1);
      chk("en0_pwm", pwm_out, 0);
      step(1);
      chk("en0_ack_once", update_ack, 0);
      enable = 1;
      measure(30);
      chk("edge_first_tick", m_first, 1);
      chk("edge_ticks", m_ticks, 3);
      chk("edge_imin", m_imin, 10);
      chk("edge_imax", m_imax, 10);
      chk("edge_hi0", m_hi[0], 0);
      chk("edge_hi1", m_hi[1], 9);
      chk("edge_hi2", m_hi[2], 30);
      chk("edge_hi3", m_hi[3], 30);
      chk("edge_log1", m_log[1], 14);
      chk("edge_log4", m_log[4], 12);
      chk("edge_acks", m_acks, 0);
      // mid-period update 3 -> 7
      step(5);
      duty = pk(0, 7, 10, 12); cfg_wr = 1;
      step(1);
      cfg_wr = 0;
      chk("upd_cur_ch1", pwm_out[1], 0);
      measure(4);
      chk("upd_cur_hi1", m_hi[1], 0);
      chk("upd_cur_ticks", m_ticks, 0);
      chk("upd_cur_acks", m_acks, 0);
      step(1);
      chk("upd_bnd_tick", period_tick, 1);
      chk("upd_bnd_ack", update_ack, 1);
      chk("upd_bnd_ch1", pwm_out[1], 1);
      measure(9);
      chk("upd_new_hi1", m_hi[1], 6);
      chk("upd_new_ticks", m_ticks, 0);
      // two writes in a period, third on the boundary clk
      step(1);
      chk("lw_bnd0_tick", period_tick, 1);
      chk("lw_bnd0_ack", update_ack, 0);
      duty = pk(0, 4, 10, 12); cfg_wr = 1;
      step(1);
      duty = pk(0, 6, 10, 12);
      step(1);
      cfg_wr = 0;
      step(7);
      duty = pk(0, 9, 10, 12); cfg_wr = 1;
      step(1);
      cfg_wr = 0;
      chk("lw_bnd1_tick", period_tick, 1);
      chk("lw_bnd1_ack", update_ack, 1);
      chk("lw_bnd1_ch1", pwm_out[1], 1);
      measure(9);
      chk("lw_p1_hi1", m_hi[1], 5);
      chk("lw_p1_acks", m_acks, 0);
      step(1);
      chk("lw_bnd2_tick", period_tick, 1);
      chk("lw_bnd2_ack", update_ack, 1);
      measure(9);
      chk("lw_p2_hi1", m_hi[1], 8);
      // stopped load P=5, then restart
      enable = 0; period = 5; duty = pk(0, 2, 5, 6); cfg_wr = 1;
      step(1);
      cfg_wr = 0;
      chk("stop_pwm", pwm_out, 0);
      chk("stop_ack", update_ack, 1);
      chk("stop_tick", period_tick, 0);
      step(1);
      chk("stop_ack_once", update_ack, 0);
      enable = 1;
      measure(15);
      chk("p5_first_tick", m_first, 1);
      chk("p5_ticks", m_ticks, 3);
      chk("p5_imin", m_imin, 5);
      chk("p5_imax", m_imax, 5);
      chk("p5_hi0", m_hi[0], 0);
      chk("p5_hi1", m_hi[1], 6);
      chk("p5_hi2", m_hi[2], 15);
      chk("p5_hi3", m_hi[3], 15);
      // center mode, FINAL_VALUE=1, P=8, duties {0,2,8,9}
      enable = 0; FINAL_VALUE = 1; period = 8; mode = 1; duty = pk(0, 2, 8, 9); cfg_wr = 1;
      step(1);
      cfg_wr = 0;
      chk("ctr_ack", update_ack, 1);
      step(1);
      enable = 1;
      measure(97);
      chk("ctr_log1", m_log[1], 0);
      chk("ctr_first_tick", m_first, 2);
      chk("ctr_ticks", m_ticks, 3);
      chk("ctr_imin", m_imin, 32);
      chk("ctr_imax", m_imax, 32);
      chk("ctr_hi0", m_hi[0], 0);
      chk("ctr_hi1", m_hi[1], 24);
      chk("ctr_hi2", m_hi[2], 96);
      chk("ctr_hi3", m_hi[3], 96);
      chk("ctr_log2", m_log[2], 14);
      chk("ctr_log6", m_log[6], 12);
      chk("ctr_log29", m_log[29], 12);
      chk("ctr_log30", m_log[30], 14);
      chk("ctr_log33", m_log[33], 14);
      // asynchronous reset while running
      chk("pre_reset_pwm", pwm_out, 14);
      #2;
      reset_n = 0;
      #1;
      chk("async_reset_pwm", pwm_out, 0);
      chk("async_reset_tick", period_tick, 0);
      chk("async_reset_ack", update_ack, 0);
      step(2);
      chk("held_reset_pwm", pwm_out, 0);
      reset_n = 1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
